// File: rtl/imem_loader.sv
// Program loader: parses SYNC/LEN/data/CSUM byte frames, writes little-endian words into
// instruction memory and holds the core in reset until a frame loads with a good checksum.
module imem_loader #(
    parameter int                  PC_WIDTH   = 32,
    parameter int                  INST_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR  = {PC_WIDTH{1'b0}},
    parameter int                  MAX_WORDS  = 256,
    parameter logic [7:0]          SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [PC_WIDTH-1:0]   wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_ld
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN0 = 3'd1,
        ST_LEN1 = 3'd2,
        ST_DATA = 3'd3,
        ST_CSUM = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    state_t                  state_r;
    state_t                  next_state_s;
    logic                    rx_ready_r;
    logic                    wr_en_r;
    logic [PC_WIDTH-1:0]     wr_addr_r;
    logic [INST_WIDTH-1:0]   wr_data_r;
    logic                    cpu_rst_r;
    logic                    done_r;
    logic                    err_r;
    logic [15:0]             words_ld_r;
    logic [15:0]             len_r;
    logic [15:0]             word_idx_r;
    logic [1:0]              byte_cnt_r;
    logic [23:0]             shift_r;
    logic [7:0]              csum_r;
    logic                    accept_s;
    logic                    last_byte_s;
    logic [15:0]             len_in_s;
    logic                    done_s;
    logic                    err_s;
    logic                    cpu_rst_s;

    assign accept_s    = rx_valid & rx_ready_r;
    assign len_in_s    = {rx_data, len_r[7:0]};
    assign last_byte_s = (byte_cnt_r == 2'd3) && (word_idx_r == (len_r - 16'd1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; advances only on an accepted byte.
    always_comb begin
        next_state_s = state_r;
        if (accept_s) begin
            case (state_r)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (rx_data == SYNC_BYTE) next_state_s = ST_LEN0;
                    else                      next_state_s = state_r;
                end
                ST_LEN0: next_state_s = ST_LEN1;
                ST_LEN1: begin
                    if (len_in_s > MAX_LEN)        next_state_s = ST_ERR;
                    else if (len_in_s == 16'd0)    next_state_s = ST_CSUM;
                    else                           next_state_s = ST_DATA;
                end
                ST_DATA: begin
                    if (last_byte_s) next_state_s = ST_CSUM;
                    else             next_state_s = ST_DATA;
                end
                ST_CSUM: begin
                    if (rx_data == csum_r) next_state_s = ST_DONE;
                    else                   next_state_s = ST_ERR;
                end
                default: next_state_s = ST_IDLE;
            endcase
        end else begin
            next_state_s = state_r;
        end
    end

    // Status outputs decoded from the upcoming state so they register alongside it.
    always_comb begin
        done_s    = (next_state_s == ST_DONE);
        err_s     = (next_state_s == ST_ERR);
        cpu_rst_s = (next_state_s != ST_DONE);
    end

    // Datapath: byte packing, checksum, write strobe and status registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ready_r <= 1'b0;
            wr_en_r    <= 1'b0;
            wr_addr_r  <= BASE_ADDR;
            wr_data_r  <= {INST_WIDTH{1'b0}};
            cpu_rst_r  <= 1'b1;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
            words_ld_r <= 16'd0;
            len_r      <= 16'd0;
            word_idx_r <= 16'd0;
            byte_cnt_r <= 2'd0;
            shift_r    <= 24'd0;
            csum_r     <= 8'd0;
        end else begin
            rx_ready_r <= 1'b1;
            wr_en_r    <= 1'b0;
            cpu_rst_r  <= cpu_rst_s;
            done_r     <= done_s;
            err_r      <= err_s;
            if (accept_s) begin
                case (state_r)
                    ST_IDLE, ST_DONE, ST_ERR: begin
                        if (rx_data == SYNC_BYTE) begin
                            csum_r     <= 8'd0;
                            byte_cnt_r <= 2'd0;
                            word_idx_r <= 16'd0;
                            words_ld_r <= 16'd0;
                        end
                    end
                    ST_LEN0: len_r[7:0]  <= rx_data;
                    ST_LEN1: len_r[15:8] <= rx_data;
                    ST_DATA: begin
                        csum_r     <= csum_r ^ rx_data;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        case (byte_cnt_r)
                            2'd0:    shift_r[7:0]   <= rx_data;
                            2'd1:    shift_r[15:8]  <= rx_data;
                            2'd2:    shift_r[23:16] <= rx_data;
                            default: begin
                                wr_en_r    <= 1'b1;
                                wr_data_r  <= INST_WIDTH'({rx_data, shift_r});
                                wr_addr_r  <= BASE_ADDR + (PC_WIDTH'(word_idx_r) << 2'd2);
                                words_ld_r <= words_ld_r + 16'd1;
                                word_idx_r <= word_idx_r + 16'd1;
                            end
                        endcase
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign rx_ready = rx_ready_r;
    assign wr_en    = wr_en_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign cpu_rst  = cpu_rst_r;
    assign done     = done_r;
    assign err      = err_r;
    assign words_ld = words_ld_r;

endmodule
